// File: rtl/rx_bb_avg_decim.sv
// ---------------------------------------------------------------------------
// rx_bb_avg_decim
//
// Boxcar-averaging decimator for the strobed RX baseband stream. It averages
// 2^K consecutive {I16,Q16} samples per rail and emits one strobed averaged
// sample per window toward the RX framer. K and a bypass bit are programmed
// through the user settings bus at address BASE:
//   [3:0] K      (values above MAX_LOG2 clamp to MAX_LOG2)
//   [4]   bypass (registered pass-through, also used when K == 0)
// Any register write restarts the window empty.
//
// Optional feature macro: RX_BB_AVG_ROUND_EN
//   defined   : add 2^(K-1) to the window sum before the shift (round half up)
//   undefined : plain arithmetic shift (floor), no rounding adder
//
// Parameters
//   BASE      settings-bus address of the control register
//   MAX_LOG2  largest K; accumulators are 16+MAX_LOG2 bits signed per rail
//
// Ports
//   clock       in   1   DSP clock
//   reset       in   1   synchronous active-high reset
//   clear       in   1   packet-control init, aborts the current window
//   enable      in   1   streaming enable; low keeps the block idle
//   set_stb     in   1   settings write strobe
//   set_addr    in   8   settings address
//   set_data    in   32  settings data
//   in_sample   in   32  {I16,Q16} two's-complement sample
//   in_strobe   in   1   in_sample valid
//   out_sample  out  32  {I16,Q16} averaged sample, held between strobes
//   out_strobe  out  1   single-cycle valid pulse for out_sample
//   phase       out  8   samples accumulated in the current window (debug)
// ---------------------------------------------------------------------------
module rx_bb_avg_decim #(
  parameter logic [7:0] BASE     = 8'd0,
  parameter int         MAX_LOG2 = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] in_sample,
  input  logic        in_strobe,
  output logic [31:0] out_sample,
  output logic        out_strobe,
  output logic [7:0]  phase
);

  localparam int         AW   = 16 + MAX_LOG2;
  localparam int         CW   = MAX_LOG2 + 1;
  localparam logic [3:0] KMAX = 4'(MAX_LOG2);

  // Registered state
  logic [3:0]           k_q, k_d;
  logic                 bypass_q, bypass_d;
  logic [CW-1:0]        count_q, count_d;
  logic signed [AW-1:0] acc_i_q, acc_i_d;
  logic signed [AW-1:0] acc_q_q, acc_q_d;
  logic [31:0]          out_sample_q, out_sample_d;
  logic                 out_strobe_q, out_strobe_d;

  // Datapath intermediates
  logic                 wr_hit;
  logic [3:0]           k_wr;
  logic                 pass_thru;
  logic [CW-1:0]        last_count;
  logic signed [AW-1:0] samp_i, samp_q;
  logic signed [AW-1:0] sum_i, sum_q;
  logic signed [AW-1:0] sum_rnd_i, sum_rnd_q;
  logic signed [AW-1:0] avg_i, avg_q;
  logic                 unused_bits;

  // Settings decode; an out-of-range K is clamped when it is written so the
  // window length never exceeds what the accumulators were sized for.
  always_comb begin
    wr_hit = set_stb && (set_addr == BASE);
    k_wr   = (set_data[3:0] > KMAX) ? KMAX : set_data[3:0];
  end

  // K == 0 means a one-sample window, which is exactly the registered
  // pass-through, so both cases share one path.
  always_comb begin
    pass_thru  = bypass_q || (k_q == 4'd0);
    last_count = (CW'(1) << k_q) - CW'(1);
  end

  // Window sum per rail. The accumulators carry MAX_LOG2 guard bits so a full
  // window of full-scale samples (plus the optional rounding term) fits.
  always_comb begin
    samp_i = {{MAX_LOG2{in_sample[31]}}, in_sample[31:16]};
    samp_q = {{MAX_LOG2{in_sample[15]}}, in_sample[15:0]};
    sum_i  = acc_i_q + samp_i;
    sum_q  = acc_q_q + samp_q;
`ifdef RX_BB_AVG_ROUND_EN
    // Half an LSB of the shifted result; only used when K >= 1.
    sum_rnd_i = sum_i + AW'((AW'(1) << k_q) >> 1);
    sum_rnd_q = sum_q + AW'((AW'(1) << k_q) >> 1);
`else
    sum_rnd_i = sum_i;
    sum_rnd_q = sum_q;
`endif
    // The mean of 16-bit samples always fits 16 bits, so truncation of the
    // upper guard bits after the shift is lossless.
    avg_i = sum_rnd_i >>> k_q;
    avg_q = sum_rnd_q >>> k_q;
  end

  // Next-state logic. Precedence below reset: clear, then a settings write,
  // then the incoming strobe. A disabled block behaves like a held clear.
  // The configuration fields still latch on a write even during clear, since
  // they describe future windows rather than the one being aborted.
  always_comb begin
    k_d          = k_q;
    bypass_d     = bypass_q;
    count_d      = count_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    out_sample_d = out_sample_q;
    out_strobe_d = 1'b0;

    if (wr_hit) begin
      k_d      = k_wr;
      bypass_d = set_data[4];
    end

    if (clear || !enable || wr_hit) begin
      // Partial window is discarded; a coinciding sample is dropped too.
      count_d = '0;
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (in_strobe) begin
      if (pass_thru) begin
        out_sample_d = in_sample;
        out_strobe_d = 1'b1;
      end else if (count_q == last_count) begin
        out_sample_d = {avg_i[15:0], avg_q[15:0]};
        out_strobe_d = 1'b1;
        count_d      = '0;
        acc_i_d      = '0;
        acc_q_d      = '0;
      end else begin
        count_d = count_q + CW'(1);
        acc_i_d = sum_i;
        acc_q_d = sum_q;
      end
    end
  end

  // State registers with synchronous reset; reset lands in bypass with K = 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      k_q          <= 4'd0;
      bypass_q     <= 1'b1;
      count_q      <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      out_sample_q <= 32'd0;
      out_strobe_q <= 1'b0;
    end else begin
      k_q          <= k_d;
      bypass_q     <= bypass_d;
      count_q      <= count_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      out_sample_q <= out_sample_d;
      out_strobe_q <= out_strobe_d;
    end
  end

  // phase reflects the window fill level; it reads 0 in pass-through.
  always_comb begin
    out_sample = out_sample_q;
    out_strobe = out_strobe_q;
    phase      = pass_thru ? 8'd0 : 8'(count_q);
  end

  // Bits that are intentionally not consumed.
  assign unused_bits = &{1'b0, set_data[31:5], avg_i[AW-1:16], avg_q[AW-1:16]};

endmodule

// File: tb/tb_rx_bb_avg_decim.sv
// ---------------------------------------------------------------------------
// tb_rx_bb_avg_decim
//
// Directed-vector bench for rx_bb_avg_decim with hand-computed expectations.
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, so a registered result of the strobe applied in one cycle
// is visible right after that cycle's edge.
// ---------------------------------------------------------------------------
module tb_rx_bb_avg_decim;

   logic        clock;
   logic        reset;
   logic        clear;
   logic        enable;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [31:0] in_sample;
   logic        in_strobe;
   logic [31:0] out_sample;
   logic        out_strobe;
   logic [7:0]  phase;

   int compareCount;
   int mismatchCount;
   int spuriousCount;

`ifdef RX_BB_AVG_ROUND_EN
   localparam logic [31:0] EXP_T2 = 32'h0003_FFFE;
`else
   localparam logic [31:0] EXP_T2 = 32'h0002_FFFD;
`endif

   rx_bb_avg_decim #(
      .BASE     (8'd0),
      .MAX_LOG2 (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .enable     (enable),
      .set_stb    (set_stb),
      .set_addr   (set_addr),
      .set_data   (set_data),
      .in_sample  (in_sample),
      .in_strobe  (in_strobe),
      .out_sample (out_sample),
      .out_strobe (out_strobe),
      .phase      (phase)
   );

   // Free-running 100 MHz-style clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Present one cycle of stream input, then return the strobe low.
   task automatic applyStimulus(input logic strobe, input logic [31:0] sample);
      in_strobe = strobe;
      in_sample = sample;
      tick();
      in_strobe = 1'b0;
   endtask

   // Settings write, optionally with a coinciding stream strobe.
   task automatic writeReg(input logic [31:0] data, input logic strobe, input logic [31:0] sample);
      set_stb   = 1'b1;
      set_addr  = 8'd0;
      set_data  = data;
      in_strobe = strobe;
      in_sample = sample;
      tick();
      set_stb   = 1'b0;
      in_strobe = 1'b0;
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      reset     = 1'b1;
      clear     = 1'b0;
      enable    = 1'b1;
      set_stb   = 1'b0;
      set_addr  = 8'd0;
      set_data  = 32'd0;
      in_sample = 32'd0;
      in_strobe = 1'b0;

      // Test 1: reset state, then default bypass pass-through.
      repeat (3) tick();
      reset = 1'b0;
      checkOutput("rst_out_sample", out_sample, 32'd0);
      checkOutput("rst_out_strobe", {31'd0, out_strobe}, 32'd0);
      checkOutput("rst_phase", {24'd0, phase}, 32'd0);
      applyStimulus(1'b1, 32'h1234_ABCD);
      checkOutput("byp_strobe", {31'd0, out_strobe}, 32'd1);
      checkOutput("byp_sample", out_sample, 32'h1234_ABCD);
      tick();
      checkOutput("byp_strobe_pulse", {31'd0, out_strobe}, 32'd0);

      // Test 2: K=2, I=1..4, Q=-1..-4.
      writeReg(32'h0000_0002, 1'b0, 32'd0);
      applyStimulus(1'b1, 32'h0001_FFFF);
      checkOutput("k2_s1_strobe", {31'd0, out_strobe}, 32'd0);
      applyStimulus(1'b1, 32'h0002_FFFE);
      applyStimulus(1'b1, 32'h0003_FFFD);
      checkOutput("k2_s3_strobe", {31'd0, out_strobe}, 32'd0);
      checkOutput("k2_s3_phase", {24'd0, phase}, 32'd3);
      applyStimulus(1'b1, 32'h0004_FFFC);
      checkOutput("k2_out_strobe", {31'd0, out_strobe}, 32'd1);
      checkOutput("k2_out_sample", out_sample, EXP_T2);
      checkOutput("k2_phase_wrap", {24'd0, phase}, 32'd0);
      tick();
      checkOutput("k2_strobe_pulse", {31'd0, out_strobe}, 32'd0);
      checkOutput("k2_sample_hold", out_sample, EXP_T2);

      // Test 3: K=8, 256 back-to-back full-scale samples.
      writeReg(32'h0000_0008, 1'b0, 32'd0);
      spuriousCount = 0;
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1'b1, 32'h7FFF_8000);
         if (out_strobe) spuriousCount++;
      end
      checkOutput("k8_no_early_out", spuriousCount, 32'd0);
      checkOutput("k8_phase_255", {24'd0, phase}, 32'd255);
      applyStimulus(1'b1, 32'h7FFF_8000);
      checkOutput("k8_out_strobe", {31'd0, out_strobe}, 32'd1);
      checkOutput("k8_out_sample", out_sample, 32'h7FFF_8000);

      // Test 4: clear aborts a partial K=2 window.
      writeReg(32'h0000_0002, 1'b0, 32'd0);
      repeat (3) applyStimulus(1'b1, 32'h0100_0100);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("clr_strobe", {31'd0, out_strobe}, 32'd0);
      checkOutput("clr_phase", {24'd0, phase}, 32'd0);
      applyStimulus(1'b1, 32'h0004_0004);
      checkOutput("clr_s1_strobe", {31'd0, out_strobe}, 32'd0);
      applyStimulus(1'b1, 32'h0004_0004);
      applyStimulus(1'b1, 32'h0004_0004);
      checkOutput("clr_s3_strobe", {31'd0, out_strobe}, 32'd0);
      applyStimulus(1'b1, 32'h0004_0004);
      checkOutput("clr_out_strobe", {31'd0, out_strobe}, 32'd1);
      checkOutput("clr_out_sample", out_sample, 32'h0004_0004);

      // Test 5: settings write coinciding with a strobe drops that sample.
      repeat (2) applyStimulus(1'b1, 32'h1000_1000);
      writeReg(32'h0000_0001, 1'b1, 32'h1000_1000);
      checkOutput("wr_strobe", {31'd0, out_strobe}, 32'd0);
      checkOutput("wr_phase", {24'd0, phase}, 32'd0);
      applyStimulus(1'b1, 32'h0006_0002);
      checkOutput("k1_s1_strobe", {31'd0, out_strobe}, 32'd0);
      checkOutput("k1_s1_phase", {24'd0, phase}, 32'd1);
      applyStimulus(1'b1, 32'h0006_0002);
      checkOutput("k1_out_strobe", {31'd0, out_strobe}, 32'd1);
      checkOutput("k1_out_sample", out_sample, 32'h0006_0002);

      // Test 6: K=15 clamps to 8; enable low ignores strobes.
      writeReg(32'h0000_000F, 1'b0, 32'd0);
      enable = 1'b0;
      spuriousCount = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 32'h0010_FFF0);
         if (out_strobe) spuriousCount++;
      end
      checkOutput("dis_no_out", spuriousCount, 32'd0);
      checkOutput("dis_phase", {24'd0, phase}, 32'd0);
      enable = 1'b1;
      spuriousCount = 0;
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1'b1, 32'h0010_FFF0);
         if (out_strobe) spuriousCount++;
      end
      checkOutput("clamp_no_early_out", spuriousCount, 32'd0);
      checkOutput("clamp_phase_255", {24'd0, phase}, 32'd255);
      applyStimulus(1'b1, 32'h0010_FFF0);
      checkOutput("clamp_out_strobe", {31'd0, out_strobe}, 32'd1);
      checkOutput("clamp_out_sample", out_sample, 32'h0010_FFF0);

      // Bypass bit overrides a nonzero K.
      writeReg(32'h0000_0012, 1'b0, 32'd0);
      applyStimulus(1'b1, 32'h5555_AAAA);
      checkOutput("byp_k2_strobe", {31'd0, out_strobe}, 32'd1);
      checkOutput("byp_k2_sample", out_sample, 32'h5555_AAAA);
      checkOutput("byp_k2_phase", {24'd0, phase}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
